// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM configuration controller.
// Build option: define PWM_CFG_RAMP_EN to compile in the duty soft-ramp.
package pwm_pkg;

  localparam int unsigned PwmW = 16;

  typedef logic [PwmW-1:0] pwm_word_t;

`ifdef PWM_CFG_RAMP_EN
  typedef enum logic [1:0] {StIdle, StPending, StRamp} pwm_state_e;
`else
  typedef enum logic [1:0] {StIdle, StPending} pwm_state_e;
`endif

endpackage

// File: rtl/pwm_duty_ramp.sv
// Saturating duty step: next = min(cur + step, target), sum kept 17 bits wide.
// Only compiled when PWM_CFG_RAMP_EN is defined.
`ifdef PWM_CFG_RAMP_EN
module pwm_duty_ramp
  import pwm_pkg::*;
(
  input  logic [PwmW-1:0] cur_i,
  input  logic [PwmW-1:0] step_i,
  input  logic [PwmW-1:0] target_i,
  output logic [PwmW-1:0] next_o,
  output logic            done_o
);

  logic [PwmW:0] sum;

  // Widened add so a large step cannot wrap past the target.
  always_comb begin
    sum    = {1'b0, cur_i} + {1'b0, step_i};
    next_o = (sum >= {1'b0, target_i}) ? target_i : sum[PwmW-1:0];
    done_o = (next_o == target_i);
  end

endmodule
`endif

// File: rtl/pwm_cfg_ctrl.sv
// PWM configuration controller: sanitises config requests and hands them to the
// PWM core either immediately (core disabled) or on the next period boundary.
// Build option: PWM_CFG_RAMP_EN adds a duty soft-ramp of RAMP_STEP per period.
module pwm_cfg_ctrl
  import pwm_pkg::*;
#(
  parameter logic [PwmW-1:0] DEFAULT_PERIOD  = 16'd100,
  parameter logic [PwmW-1:0] DEFAULT_DUTY    = 16'd50,
  parameter logic [PwmW-1:0] DEFAULT_DIVISOR = 16'd1,
  parameter logic [PwmW-1:0] RAMP_STEP       = 16'd1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [PwmW-1:0] cfg_period_i,
  input  logic [PwmW-1:0] cfg_duty_i,
  input  logic [PwmW-1:0] cfg_divisor_i,
  input  logic            cfg_enable_i,
  input  logic            period_end_i,
  output logic [PwmW-1:0] period_o,
  output logic [PwmW-1:0] duty_cycle_o,
  output logic [PwmW-1:0] divisor_o,
  output logic            enable_o,
  output logic            busy_o,
  output logic            cfg_err_o
);

  pwm_state_e state_q, state_d;
  pwm_word_t  period_q, period_d, duty_q, duty_d, div_q, div_d;
  pwm_word_t  sh_period_q, sh_period_d, sh_duty_q, sh_duty_d, sh_div_q, sh_div_d;
  logic       enable_q, enable_d, sh_en_q, sh_en_d;
  logic       busy_q, err_q, err_d;

  logic       accept, duty_clamp, div_fix;
  pwm_word_t  san_duty, san_div;

  assign cfg_ready_o = (state_q == StIdle);
  assign accept      = cfg_valid_i & cfg_ready_o;
  assign duty_clamp  = (cfg_duty_i > cfg_period_i);
  assign div_fix     = (cfg_divisor_i == '0);
  assign san_duty    = duty_clamp ? cfg_period_i : cfg_duty_i;
  assign san_div     = div_fix ? pwm_word_t'(1) : cfg_divisor_i;

`ifdef PWM_CFG_RAMP_EN
  pwm_word_t ramp_next;
  logic      ramp_done;

  // Steps from the live duty toward the shadowed target.
  pwm_duty_ramp u_duty_ramp (
    .cur_i   (duty_q),
    .step_i  (RAMP_STEP),
    .target_i(sh_duty_q),
    .next_o  (ramp_next),
    .done_o  (ramp_done)
  );
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^RAMP_STEP;
`endif

  // Next-state and output-register logic; outputs only move on accept-while-disabled
  // or on a period_end seen outside the accept cycle.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    duty_d      = duty_q;
    div_d       = div_q;
    enable_d    = enable_q;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    sh_div_d    = sh_div_q;
    sh_en_d     = sh_en_q;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (cfg_period_i == '0) begin
            err_d = 1'b1;
          end else begin
            err_d       = duty_clamp | div_fix;
            sh_period_d = cfg_period_i;
            sh_duty_d   = san_duty;
            sh_div_d    = san_div;
            sh_en_d     = cfg_enable_i;
            if (!enable_q) begin
              period_d = cfg_period_i;
              div_d    = san_div;
              enable_d = cfg_enable_i;
              duty_d   = san_duty;
`ifdef PWM_CFG_RAMP_EN
              // Fresh enable starts from zero duty and ramps up.
              if (cfg_enable_i && (san_duty != '0)) begin
                duty_d  = '0;
                state_d = StRamp;
              end
`endif
            end else begin
              state_d = StPending;
            end
          end
        end
      end

      StPending: begin
        if (period_end_i) begin
          period_d = sh_period_q;
          div_d    = sh_div_q;
          enable_d = sh_en_q;
          state_d  = StIdle;
`ifdef PWM_CFG_RAMP_EN
          if (sh_duty_q <= duty_q) begin
            duty_d = sh_duty_q;
          end else begin
            duty_d = ramp_next;
            if (!ramp_done) state_d = StRamp;
          end
`else
          duty_d = sh_duty_q;
`endif
        end
      end

`ifdef PWM_CFG_RAMP_EN
      StRamp: begin
        if (period_end_i) begin
          duty_d = ramp_next;
          if (ramp_done) state_d = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset to defaults.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      period_q    <= DEFAULT_PERIOD;
      duty_q      <= DEFAULT_DUTY;
      div_q       <= DEFAULT_DIVISOR;
      enable_q    <= 1'b0;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
      sh_div_q    <= '0;
      sh_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      div_q       <= div_d;
      enable_q    <= enable_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
      sh_div_q    <= sh_div_d;
      sh_en_q     <= sh_en_d;
      busy_q      <= (state_d != StIdle);
      err_q       <= err_d;
    end
  end

  assign period_o     = period_q;
  assign duty_cycle_o = duty_q;
  assign divisor_o    = div_q;
  assign enable_o     = enable_q;
  assign busy_o       = busy_q;
  assign cfg_err_o    = err_q;

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Scoreboard bench for pwm_cfg_ctrl: a behavioural model predicts the visible
// outputs after every clock edge; a monitor compares them against the DUT.
module tb_pwm_cfg_ctrl;

  localparam logic [15:0] Step = 16'd10;
`ifdef PWM_CFG_RAMP_EN
  localparam bit RampOn = 1'b1;
`else
  localparam bit RampOn = 1'b0;
`endif
  localparam int ModeIdle = 0;
  localparam int ModePend = 1;
  localparam int ModeRamp = 2;

  logic        clk = 1'b0;
  logic        reset, cfg_valid, cfg_ready, cfg_enable, period_end;
  logic [15:0] cfg_period, cfg_duty, cfg_divisor;
  logic [15:0] period, duty_cycle, divisor;
  logic        enable, busy, cfg_err;

  always #5 clk = ~clk;

  pwm_cfg_ctrl #(
    .DEFAULT_PERIOD (16'd100),
    .DEFAULT_DUTY   (16'd50),
    .DEFAULT_DIVISOR(16'd1),
    .RAMP_STEP      (Step)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_period_i (cfg_period),
    .cfg_duty_i   (cfg_duty),
    .cfg_divisor_i(cfg_divisor),
    .cfg_enable_i (cfg_enable),
    .period_end_i (period_end),
    .period_o     (period),
    .duty_cycle_o (duty_cycle),
    .divisor_o    (divisor),
    .enable_o     (enable),
    .busy_o       (busy),
    .cfg_err_o    (cfg_err)
  );

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] duty;
    logic [15:0] dv;
    logic        en;
    logic        busy;
    logic        rdy;
    logic        err;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: visible settings, controller mode and the held request.
  int m_per, m_duty, m_div, m_mode;
  int t_per, t_duty, t_div;
  bit m_en, t_en, m_err;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int per, input int du,
                            input int dv, input bit en, input bit pe, output bit acc);
    acc   = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_per = 100; m_duty = 50; m_div = 1; m_en = 1'b0; m_mode = ModeIdle;
      t_per = 0; t_duty = 0; t_div = 0; t_en = 1'b0;
    end else if (m_mode == ModeIdle) begin
      if (v) begin
        acc = 1'b1;
        if (per == 0) begin
          m_err = 1'b1;
        end else begin
          t_per  = per;
          t_duty = min2(du, per);
          t_div  = (dv == 0) ? 1 : dv;
          t_en   = en;
          m_err  = (du > per) || (dv == 0);
          if (!m_en) begin
            m_per = t_per; m_div = t_div; m_en = t_en; m_duty = t_duty;
            if (RampOn && en && t_duty > 0) begin
              m_duty = 0;
              m_mode = ModeRamp;
            end
          end else begin
            m_mode = ModePend;
          end
        end
      end
    end else if (m_mode == ModePend) begin
      if (pe) begin
        m_per = t_per; m_div = t_div; m_en = t_en;
        if (RampOn && t_duty > m_duty) begin
          m_duty = min2(m_duty + int'(Step), t_duty);
          m_mode = (m_duty == t_duty) ? ModeIdle : ModeRamp;
        end else begin
          m_duty = t_duty;
          m_mode = ModeIdle;
        end
      end
    end else begin
      if (pe) begin
        m_duty = min2(m_duty + int'(Step), t_duty);
        if (m_duty == t_duty) m_mode = ModeIdle;
      end
    end
  endtask

  function automatic obs_t expected();
    obs_t o;
    o.per  = 16'(m_per);
    o.duty = 16'(m_duty);
    o.dv   = 16'(m_div);
    o.en   = m_en;
    o.busy = (m_mode != ModeIdle);
    o.rdy  = (m_mode == ModeIdle);
    o.err  = m_err;
    return o;
  endfunction

  // Monitor: after every rising edge, compare DUT outputs with the oldest prediction.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{per: period, duty: duty_cycle, dv: divisor, en: enable, busy: busy,
              rdy: cfg_ready, err: cfg_err};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got per=%0d duty=%0d div=%0d en=%0b busy=%0b rdy=%0b err=%0b want per=%0d duty=%0d div=%0d en=%0b busy=%0b rdy=%0b err=%0b",
                   $time, a.per, a.duty, a.dv, a.en, a.busy, a.rdy, a.err,
                   e.per, e.duty, e.dv, e.en, e.busy, e.rdy, e.err);
        end
      end
    end
  end

  // One clock: predict from the inputs currently driven, then move to the next negedge.
  task automatic tick();
    bit acc;
    model_step(reset, cfg_valid, int'(cfg_period), int'(cfg_duty), int'(cfg_divisor),
               cfg_enable, period_end, acc);
    exp_q.push_back(expected());
    @(posedge clk);
    @(negedge clk);
    if (acc) cfg_valid = 1'b0;
    period_end = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic issue(input int per, input int du, input int dv, input bit en);
    cfg_period  = 16'(per);
    cfg_duty    = 16'(du);
    cfg_divisor = 16'(dv);
    cfg_enable  = en;
    cfg_valid   = 1'b1;
  endtask

  // Hold the request until taken; period_end pulses randomly so PENDING can drain.
  task automatic send(input int per, input int du, input int dv, input bit en);
    int n = 0;
    issue(per, du, dv, en);
    while (cfg_valid && n < 200) begin
      tick();
      n++;
      if (cfg_valid) period_end = ($urandom_range(0, 2) == 0);
    end
    if (cfg_valid) begin
      errors++;
      $display("FAIL accept_timeout got valid_pending=1 want accepted within 200 cycles");
      cfg_valid = 1'b0;
    end
  endtask

  // pe_mode: 0 none, 1 every cycle, 2 random.
  task automatic run(input int n, input int pe_mode);
    for (int i = 0; i < n; i++) begin
      if (pe_mode == 1) period_end = 1'b1;
      else if (pe_mode == 2) period_end = ($urandom_range(0, 3) == 0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_enable = 1'b0; period_end = 1'b0;
    cfg_period = '0; cfg_duty = '0; cfg_divisor = '0;
    @(negedge clk);

    // Reset, then idle defaults.
    reset = 1'b1; tick();
    reset = 1'b1; tick();
    run(3, 0);

    // Disabled core: immediate update.
    send(200, 75, 2, 1'b1);
    run(2, 0);
    run(12, 1);

    // Enabled core: deferred update; a period_end on the accept cycle is ignored.
    issue(200, 120, 2, 1'b1);
    period_end = 1'b1;
    tick();
    run(3, 0);
    run(1, 1);
    run(12, 1);

    // Clamp duty, fix divisor, then a rejected zero period.
    send(100, 150, 0, 1'b1);
    run(2, 0);
    run(12, 1);
    send(0, 20, 3, 1'b1);
    run(3, 0);

    // Ramp from a disabled core, then reset in the middle of a ramp.
    reset = 1'b1; tick();
    send(100, 35, 1, 1'b1);
    run(7, 1);
    reset = 1'b1; tick();
    send(300, 90, 1, 1'b1);
    run(2, 1);
    reset = 1'b1; tick();
    run(3, 1);

    // Reset in the middle of PENDING.
    send(50, 10, 1, 1'b1);
    run(8, 1);
    send(60, 40, 4, 1'b1);
    reset = 1'b1; tick();
    run(3, 1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!cfg_valid && $urandom_range(0, 5) == 0) begin
        issue(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 300)),
              int'($urandom_range(0, 350)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)));
      end
      period_end = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      tick();
    end

    run(2, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
